toggle_echo_checker: RTL and testbench

- Clocked checker directly downstream of the VPI/prsim co-simulated inverter chain.
- Samples the stimulus net driving the chain and the chain's final output, then pairs each stimulus edge with the next output edge in order.
- Checks the output value's polarity, measures the propagation latency in clock cycles, and keeps pass/fail statistics for the bench to print at end of simulation.
- `clk` must run at least 4x faster than the fastest stimulus toggle.

---
 rtl/toggle_echo_checker_pkg.sv | 20 ++
 rtl/toggle_echo_checker_if.sv | 42 ++++
 rtl/toggle_echo_checker_edge_sync.sv | 33 +++
 rtl/toggle_echo_checker.sv | 203 ++++++++++++++++++++
 tb/tb_toggle_echo_checker.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/toggle_echo_checker_pkg.sv
// Shared types and constants for the toggle/echo checker.
// Contents:
//   state_e    - checker state machine encoding
//   ARM_CYCLES - cycles spent in ARM before checking starts
//   ARM_W      - width of the ARM down-counter
// The FIFO entry struct lives in the top module because its stamp width
// follows the LAT_W parameter there.
package echo_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam int ARM_CYCLES = 3;
  localparam int ARM_W      = $clog2(ARM_CYCLES);

endpackage

// File: rtl/toggle_echo_checker_if.sv
// Bus bundle between the bench/controller and the toggle/echo checker.
// Ports:
//   enable, clr_stats      - control inputs to the checker
//   stim_in, chain_out     - asynchronous nets observed by the checker
//   match_cnt, err_cnt     - pairing statistics
//   last_latency, max_latency - latency results in clock cycles
//   pending                - FIFO occupancy
//   overflow_err, timeout_err - sticky fault flags
//   armed                  - checker is in RUN
// master drives the inputs; slave is the checker.
interface toggle_echo_checker_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int LAT_W = 8
);

  logic                     enable;
  logic                     clr_stats;
  logic                     stim_in;
  logic                     chain_out;
  logic [CNT_W-1:0]         match_cnt;
  logic [CNT_W-1:0]         err_cnt;
  logic [LAT_W-1:0]         last_latency;
  logic [LAT_W-1:0]         max_latency;
  logic [$clog2(DEPTH):0]   pending;
  logic                     overflow_err;
  logic                     timeout_err;
  logic                     armed;

  modport master (
    output enable, clr_stats, stim_in, chain_out,
    input  match_cnt, err_cnt, last_latency, max_latency, pending,
           overflow_err, timeout_err, armed
  );

  modport slave (
    input  enable, clr_stats, stim_in, chain_out,
    output match_cnt, err_cnt, last_latency, max_latency, pending,
           overflow_err, timeout_err, armed
  );

endinterface

// File: rtl/toggle_echo_checker_edge_sync.sv
// Two-flop synchronizer followed by a history flop; flags a toggle of the
// synchronized level for one cycle.
// Ports:
//   clk, rst_n - sampling clock, async active-low reset
//   async_i    - asynchronous input net
//   level_o    - synchronized level
//   edge_o     - high for one cycle after the synchronized level changes
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic edge_o
);

  logic sync1_q, sync2_q, hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign edge_o  = sync2_q ^ hist_q;

endmodule

// File: rtl/toggle_echo_checker.sv
// Pairs each stimulus edge with the next chain-output edge, checks polarity,
// measures latency in clock cycles and keeps saturating statistics.
// Ports:
//   clk, rst_n - sampling clock, async active-low reset
//   bus        - toggle_echo_checker_if.slave (controls, observed nets, results)
//
// state | meaning
// IDLE  | checker off, FIFO empty, statistics held
// ARM   | edges ignored while the history flops settle
// RUN   | pushing stimulus edges, popping on chain edges
// FAULT | overflow or timeout seen; everything frozen
module toggle_echo_checker
  import echo_chk_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter bit INVERT  = 1'b1,
  parameter int CNT_W   = 16,
  parameter int LAT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input logic            clk,
  input logic            rst_n,
  toggle_echo_checker_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [LAT_W-1:0] AGE_LIMIT = LAT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [ARM_W-1:0] ARM_LOAD  = ARM_W'(ARM_CYCLES - 1);

  typedef struct packed {
    logic             value;
    logic [LAT_W-1:0] stamp;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  logic stim_lvl, stim_edge, chain_lvl, chain_edge;

  edge_sync u_sync_stim (
    .clk(clk), .rst_n(rst_n), .async_i(bus.stim_in),
    .level_o(stim_lvl), .edge_o(stim_edge)
  );

  edge_sync u_sync_chain (
    .clk(clk), .rst_n(rst_n), .async_i(bus.chain_out),
    .level_o(chain_lvl), .edge_o(chain_edge)
  );

  state_e           state_q, state_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [LAT_W-1:0] ts_q;
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] match_q, match_d, err_q, err_d;
  logic [LAT_W-1:0] last_lat_q, last_lat_d, max_lat_q, max_lat_d;
  logic             ovf_q, ovf_d, tmo_q, tmo_d, armed_q, armed_d;
  logic             push_en, pop_en;
  entry_t           head;
  logic [LAT_W-1:0] head_age;
  logic             fifo_empty, fifo_full;

  assign head       = mem_q[rd_ptr_q];
  assign head_age   = ts_q - head.stamp;   // wraps modulo 2^LAT_W
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OCC_FULL);

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    match_d    = match_q;
    err_d      = err_q;
    last_lat_d = last_lat_q;
    max_lat_d  = max_lat_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    push_en    = 1'b0;
    pop_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d   = ARM;
          arm_cnt_d = ARM_LOAD;
        end
      end
      ARM: begin
        if (arm_cnt_q == '0) state_d = RUN;
        else                 arm_cnt_d = arm_cnt_q - ARM_W'(1);
      end
      RUN: begin
        if (chain_edge) begin
          if (fifo_empty) begin
            err_d = sat_inc(err_q);   // spurious: judged on occupancy at cycle start
          end else begin
            pop_en = 1'b1;
            if ((head.value ^ INVERT) == chain_lvl) match_d = sat_inc(match_q);
            else                                    err_d   = sat_inc(err_q);
            last_lat_d = head_age;
            if (head_age > max_lat_q) max_lat_d = head_age;
          end
        end
        if (stim_edge) begin
          // a same-cycle pop frees the slot, so a full FIFO still accepts
          if (fifo_full && !pop_en) begin
            ovf_d   = 1'b1;
            state_d = FAULT;
          end else begin
            push_en = 1'b1;
          end
        end
        if (!fifo_empty && (head_age >= AGE_LIMIT)) begin
          tmo_d   = 1'b1;
          state_d = FAULT;
        end
        if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        occ_d = occ_q + OCC_W'(push_en) - OCC_W'(pop_en);
      end
      default: ;
    endcase

    if (bus.clr_stats && (state_q != IDLE)) begin
      state_d    = ARM;
      arm_cnt_d  = ARM_LOAD;
      match_d    = '0;
      err_d      = '0;
      last_lat_d = '0;
      max_lat_d  = '0;
      ovf_d      = 1'b0;
      tmo_d      = 1'b0;
      push_en    = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
    end

    if (!bus.enable) begin
      state_d  = IDLE;
      push_en  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end

    armed_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      arm_cnt_q  <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      match_q    <= '0;
      err_q      <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      ts_q       <= ts_q + LAT_W'(1);
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      match_q    <= match_d;
      err_q      <= err_d;
      last_lat_q <= last_lat_d;
      max_lat_q  <= max_lat_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      armed_q    <= armed_d;
    end
  end

  // Storage only; validity is tracked by the pointers and occupancy.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= {stim_lvl, ts_q};
  end

  assign bus.match_cnt    = match_q;
  assign bus.err_cnt      = err_q;
  assign bus.last_latency = last_lat_q;
  assign bus.max_latency  = max_lat_q;
  assign bus.pending      = occ_q;
  assign bus.overflow_err = ovf_q;
  assign bus.timeout_err  = tmo_q;
  assign bus.armed        = armed_q;

endmodule

// File: tb/tb_toggle_echo_checker.sv
module tb_toggle_echo_checker;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  localparam int LAT_W   = 8;
  localparam int TIMEOUT = 64;
  localparam bit INVERT  = 1'b1;

  logic clk = 1'b0;
  logic rst_n;

  toggle_echo_checker_if #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LAT_W(LAT_W)) bus();

  toggle_echo_checker #(
    .DEPTH(DEPTH), .INVERT(INVERT), .CNT_W(CNT_W), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit value; int at; } stim_t;
  typedef struct { bit is_match; int last_lat; int max_lat; } exp_t;

  stim_t sq[$];      // outstanding stimulus edges, reference model
  exp_t  exp_q[$];   // scoreboard of expected statistic updates

  int n_checks = 0;
  int n_pass   = 0;
  bit model_run = 0;
  bit exp_ovf = 0, exp_tmo = 0;
  int m_match = 0, m_err = 0, m_last = 0, m_max = 0;
  bit stim_lvl = 0, chain_lvl = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_clear();
    m_match = 0; m_err = 0; m_last = 0; m_max = 0;
    exp_ovf = 0; exp_tmo = 0;
    sq.delete();
  endtask

  task automatic stim_toggle();
    stim_t s;
    stim_lvl = ~stim_lvl;
    bus.stim_in = stim_lvl;
    if (!model_run) return;
    if (sq.size() == DEPTH) begin
      exp_ovf = 1;
      model_run = 0;
    end else begin
      s.value = stim_lvl;
      s.at = cyc;
      sq.push_back(s);
    end
  endtask

  task automatic chain_toggle();
    stim_t s;
    exp_t e;
    int lat;
    chain_lvl = ~chain_lvl;
    bus.chain_out = chain_lvl;
    if (!model_run) return;
    if (sq.size() == 0) begin
      m_err++;
      e.is_match = 0;
    end else begin
      s = sq.pop_front();
      lat = (cyc - s.at) % (1 << LAT_W);
      e.is_match = ((s.value ^ INVERT) == chain_lvl);
      if (e.is_match) m_match++; else m_err++;
      m_last = lat;
      if (lat > m_max) m_max = lat;
    end
    e.last_lat = m_last;
    e.max_lat  = m_max;
    exp_q.push_back(e);
  endtask

  task automatic echo_run(input int n, input bit rnd);
    int gap;
    int d;
    for (int i = 0; i < n; i++) begin
      gap = 20;
      d = 5;
      if (rnd) begin
        gap = $urandom_range(20, 8);
        d = $urandom_range(6, 1);
      end
      stim_toggle();
      repeat (d) @(negedge clk);
      chain_toggle();
      repeat (gap - d) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_match"}, bus.match_cnt, m_match);
    chk({tag, "_err"}, bus.err_cnt, m_err);
    chk({tag, "_last_lat"}, bus.last_latency, m_last);
    chk({tag, "_max_lat"}, bus.max_latency, m_max);
    chk({tag, "_pending"}, bus.pending, sq.size());
    chk({tag, "_ovf"}, bus.overflow_err, exp_ovf);
    chk({tag, "_tmo"}, bus.timeout_err, exp_tmo);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_match"}, bus.match_cnt, 0);
    chk({tag, "_err"}, bus.err_cnt, 0);
    chk({tag, "_last_lat"}, bus.last_latency, 0);
    chk({tag, "_max_lat"}, bus.max_latency, 0);
    chk({tag, "_pending"}, bus.pending, 0);
    chk({tag, "_ovf"}, bus.overflow_err, 0);
    chk({tag, "_tmo"}, bus.timeout_err, 0);
    chk({tag, "_armed"}, bus.armed, 0);
  endtask

  task automatic rearm(input bit s0, input bit c0);
    bus.enable = 1'b0;
    model_run = 0;
    sq.delete();
    stim_lvl = s0; chain_lvl = c0;
    bus.stim_in = s0; bus.chain_out = c0;
    repeat (5) @(negedge clk);
    chk("idle_armed", bus.armed, 0);
    chk("idle_flushed", bus.pending, 0);
    chk("idle_kept_match", bus.match_cnt, m_match);
    chk("idle_kept_err", bus.err_cnt, m_err);
    chk("idle_kept_ovf", bus.overflow_err, exp_ovf);
    chk("idle_kept_tmo", bus.timeout_err, exp_tmo);
    bus.enable = 1'b1;
    @(negedge clk);
    bus.clr_stats = 1'b1;
    @(negedge clk);
    bus.clr_stats = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
    chk("rearm_run", bus.armed, 1);
    model_run = 1;
  endtask

  // Monitor: every statistic update pops one scoreboard entry.
  logic [CNT_W-1:0] prev_m = '0, prev_e = '0;
  initial begin
    exp_t e;
    bit got_match;
    forever begin
      @(negedge clk);
      if (bus.match_cnt !== prev_m || bus.err_cnt !== prev_e) begin
        if (bus.match_cnt == '0 && bus.err_cnt == '0) begin
          // statistics cleared by clr_stats or reset
        end else if ((bus.match_cnt == CNT_W'(prev_m + 1'b1) && bus.err_cnt == prev_e) ||
                     (bus.err_cnt == CNT_W'(prev_e + 1'b1) && bus.match_cnt == prev_m)) begin
          got_match = (bus.match_cnt != prev_m);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: counters moved to match=%0d err=%0d with no expected event",
                     bus.match_cnt, bus.err_cnt);
          end else begin
            e = exp_q.pop_front();
            chk("sb_polarity", got_match, e.is_match);
            chk("sb_last_lat", bus.last_latency, e.last_lat);
            chk("sb_max_lat", bus.max_latency, e.max_lat);
          end
        end else begin
          n_checks++;
          $display("FAIL sb_cnt_step: match %0d->%0d err %0d->%0d", prev_m, bus.match_cnt,
                   prev_e, bus.err_cnt);
        end
        prev_m = bus.match_cnt;
        prev_e = bus.err_cnt;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.clr_stats = 1'b0;
    bus.stim_in = 1'b0; bus.chain_out = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // normal echo: chain = ~stim, 5 cycles later
    rearm(1'b0, 1'b1);
    echo_run(10, 1'b0);
    settle();
    chk("echo_match10", bus.match_cnt, 10);
    chk("echo_lat5", bus.last_latency, 5);
    check_stats("echo");

    // randomized timing, same polarity
    echo_run(12, 1'b1);
    settle();
    check_stats("rand_echo");

    // polarity error: chain follows stim
    rearm(1'b0, 1'b0);
    echo_run(10, 1'b0);
    settle();
    chk("pol_err10", bus.err_cnt, 10);
    check_stats("polarity");
    chk("pol_armed", bus.armed, 1);

    // spurious chain pulse on an empty FIFO
    rearm(1'b0, 1'b1);
    chain_toggle();
    repeat (30) @(negedge clk);
    chain_toggle();
    settle();
    chk("spur_err2", bus.err_cnt, 2);
    check_stats("spurious");
    chk("spur_armed", bus.armed, 1);

    // timeout: stim edge with no echo; flagged 64 cycles after the push
    stim_toggle();
    repeat (66) @(posedge clk);
    #1 chk("tmo_before", bus.timeout_err, 0);
    @(posedge clk);
    #1 chk("tmo_at", bus.timeout_err, 1);
    chk("tmo_armed", bus.armed, 0);
    model_run = 0;
    exp_tmo = 1;
    @(negedge clk);
    stim_toggle();
    repeat (3) @(negedge clk);
    chain_toggle();
    settle();
    check_stats("fault_frozen");
    bus.clr_stats = 1'b1;
    @(negedge clk);
    bus.clr_stats = 1'b0;
    model_clear();
    check_stats("clr");
    repeat (2) @(negedge clk);
    chk("clr_armed_k2", bus.armed, 0);
    @(negedge clk);
    chk("clr_armed_k3", bus.armed, 1);
    model_run = 1;

    // overflow: 9 stim edges, no echoes
    for (int i = 0; i < 9; i++) begin
      stim_toggle();
      repeat (6) @(negedge clk);
    end
    settle();
    chk("ovf_flag", bus.overflow_err, 1);
    chk("ovf_pending8", bus.pending, DEPTH);
    chk("ovf_armed", bus.armed, 0);
    check_stats("overflow");

    // reset in mid-operation
    rearm(1'b0, 1'b1);
    echo_run(4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stim_toggle();
      repeat (6) @(negedge clk);
    end
    settle();
    chk("pre_rst_pending3", bus.pending, 3);
    chk("pre_rst_match4", bus.match_cnt, 4);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    model_run = 0;
    model_clear();
    stim_lvl = 1'b1; chain_lvl = 1'b1;
    bus.stim_in = 1'b1; bus.chain_out = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    chk("post_rst_armed", bus.armed, 1);
    check_stats("post_rst");
    model_run = 1;
    echo_run(8, 1'b1);
    settle();
    check_stats("post_rst_echo");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
